// File: rtl/dmem_lsu.sv
// dmem_lsu - load/store unit in front of a synchronous data memory.
//
// Takes one load or store at a time from execute. It drives the dmem with a
// word address, byte enables and store data copied into every lane. It
// returns aligned, sign- or zero-extended load data to writeback together
// with the destination register.
//
// Timing, counted from the edge that accepts a request:
//   +1 cycle (ISSUE) mem_re_o or mem_we_o is high for one cycle
//   +2 cycle (WAIT)  mem_rdata_i is sampled at the end of this cycle
//   +3 cycle (RESP)  resp_valid_o pulses for one cycle
// A store returns to IDLE straight after ISSUE.
//
// Ports:
//   clock_i, reset_n_i  clock and synchronous active-low reset
//   flush_i             cancels a pending load response and blocks new requests
//   req_*               request from execute (valid/ready handshake)
//   mem_*               synchronous dmem interface (read data one cycle after re)
//   resp_*              load result to writeback
//   misalign_o          misaligned-access pulse (trap build only, else tied 0)
//
// Build option:
//   DMEM_LSU_MISALIGN_TRAP_EN  when defined, a misaligned op is accepted but
//                              does not touch memory; it pulses misalign_o
//                              instead. When undefined, the offset is forced
//                              down to natural alignment and the access
//                              proceeds normally.
module dmem_lsu #(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t state, state_nxt;

    // rst_q is high for the cycle after a resetting edge. It keeps
    // req_ready_o low in that cycle so that every output reads 0 there.
    logic rst_q;
    logic accept;

    // Request decode.
    logic [1:0] req_off;
    logic       req_byte, req_half, req_word, req_trap;
    logic [1:0] req_eff_off;
    logic [3:0] req_be;
    logic [XLEN-1:0] req_wrep;

    // Operation captured at accept.
    logic       op_we, op_trap, op_byte, op_half, op_uns;
    logic [1:0] op_off;
    logic [4:0] op_rd;

    // Next values of the registered outputs.
    logic [ADDR_W-1:0] addr_d;
    logic              re_d, we_d, resp_load;
    logic [3:0]        be_d;
    logic [XLEN-1:0]   wdata_d, rdata_d, shifted;
    logic [4:0]        rd_d;
    logic              resp_vld_q;

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[XLEN-1:ADDR_W];

    assign req_ready_o = (state == S_IDLE) & ~rst_q & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;

    assign req_off  = req_addr_i[1:0];
    assign req_byte = (req_funct3_i[1:0] == 2'b00);
    assign req_half = (req_funct3_i[1:0] == 2'b01);
    assign req_word = ~req_byte & ~req_half;   // 010, 011, 110 and 111 all act as W

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    assign req_trap = (req_half & req_off[0]) | (req_word & (|req_off));
`else
    assign req_trap = 1'b0;
`endif

    // Without the trap build this snaps the offset to alignment. With it,
    // misaligned ops never reach memory and aligned ops keep their offset.
    assign req_eff_off = req_byte ? req_off :
                         req_half ? {req_off[1], 1'b0} : 2'b00;

    assign req_be   = req_byte ? (4'b0001 << req_eff_off) :
                      req_half ? (4'b0011 << req_eff_off) : 4'b1111;
    assign req_wrep = req_byte ? {4{req_wdata_i[7:0]}} :
                      req_half ? {2{req_wdata_i[15:0]}} : req_wdata_i;

    // State register.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            // A store, a trapped op or a flushed load all finish here. A
            // flushed load's read still went out this cycle; its data is dropped.
            S_ISSUE: state_nxt = (op_we | op_trap | flush_i) ? S_IDLE : S_WAIT;
            S_WAIT:  state_nxt = flush_i ? S_IDLE : S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign shifted = mem_rdata_i >> {op_off, 3'b000};

    // Output logic: next values for the registered dmem/response outputs.
    always_comb begin
        re_d      = accept & ~req_we_i & ~req_trap;
        we_d      = accept &  req_we_i & ~req_trap;
        be_d      = we_d ? req_be : 4'b0000;
        addr_d    = accept ? {req_addr_i[ADDR_W-1:2], 2'b00} : mem_addr_o;
        wdata_d   = accept ? req_wrep : mem_wdata_o;
        resp_load = (state == S_WAIT) & ~flush_i;
        rdata_d   = resp_data_o;
        rd_d      = resp_rd_o;
        if (resp_load) begin
            rd_d = op_rd;
            if (op_byte)      rdata_d = {{24{~op_uns & shifted[7]}},  shifted[7:0]};
            else if (op_half) rdata_d = {{16{~op_uns & shifted[15]}}, shifted[15:0]};
            else              rdata_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rst_q       <= 1'b1;
            mem_addr_o  <= '0;
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
            resp_vld_q  <= 1'b0;
            resp_data_o <= '0;
            resp_rd_o   <= '0;
            op_we       <= 1'b0;
            op_trap     <= 1'b0;
            op_byte     <= 1'b0;
            op_half     <= 1'b0;
            op_uns      <= 1'b0;
            op_off      <= 2'b00;
            op_rd       <= '0;
        end else begin
            rst_q       <= 1'b0;
            mem_addr_o  <= addr_d;
            mem_re_o    <= re_d;
            mem_we_o    <= we_d;
            mem_be_o    <= be_d;
            mem_wdata_o <= wdata_d;
            resp_vld_q  <= resp_load;
            resp_data_o <= rdata_d;
            resp_rd_o   <= rd_d;
            if (accept) begin
                op_we   <= req_we_i;
                op_trap <= req_trap;
                op_byte <= req_byte;
                op_half <= req_half;
                op_uns  <= req_funct3_i[2];
                op_off  <= req_eff_off;
                op_rd   <= req_rd_i;
            end
        end
    end

    // A flush raised during RESP still kills the pulse in that same cycle.
    assign resp_valid_o = resp_vld_q & ~flush_i;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) mis_q <= 1'b0;
        else            mis_q <= accept & req_trap;
    end
    assign misalign_o = mis_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
    localparam int ADDR_W = 10;
    localparam int NW     = 1 << (ADDR_W - 2);

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready, req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        resp_valid, misalign;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_rd_i(req_rd), .mem_addr_o(mem_addr), .mem_re_o(mem_re),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .resp_rd_o(resp_rd), .misalign_o(misalign)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else n_pass++;
    endtask

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Environment: synchronous dmem driven by the DUT; pokes come from the stimulus.
    logic [31:0] dmem [NW];
    bit          filled = 0;
    logic        poke_en = 1'b0;
    int          poke_idx = 0;
    logic [31:0] poke_val = '0;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < NW; i++) dmem[i] <= init_word(i);
            filled <= 1;
        end else begin
            if (mem_we)
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) dmem[mem_addr[ADDR_W-1:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
            if (poke_en) dmem[poke_idx] <= poke_val;
        end
        mem_rdata <= mem_re ? dmem[mem_addr[ADDR_W-1:2]] : $urandom();
    end

    // Behavioural model: transaction view of the unit with its own shadow memory.
    logic [31:0] mmem [NW];
    bit          m_filled = 0;
    bit          model_on = 0;
    bit          m_rst = 0;
    int          m_busy = 0;    // cycles the unit stays unavailable
    int          p_stage = 0;   // 0 none, 1 read issuing, 2 data arriving
    logic [31:0] p_data = '0;
    logic [4:0]  p_rd = '0;
    logic        e_re = 0, e_we = 0, e_mis = 0, e_rv = 0;
    logic [3:0]  e_be = '0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [31:0] e_wdata = '0, e_rdata = '0;
    logic [4:0]  e_rrd = '0;

    always @(posedge clk) begin
        bit rdy;
        int nb, wi;
        logic [1:0] off;
        bit mis;
        logic [31:0] v;
        if (!m_filled) begin
            for (int i = 0; i < NW; i++) mmem[i] = init_word(i);
            m_filled = 1;
        end
        if (poke_en) mmem[poke_idx] = poke_val;
        if (!rst_n) begin
            model_on = 1; m_rst = 1; m_busy = 0; p_stage = 0;
            e_re = 0; e_we = 0; e_mis = 0; e_be = 0; e_addr = 0; e_wdata = 0;
            e_rv = 0; e_rdata = 0; e_rrd = 0;
        end else if (model_on) begin
            rdy = (m_busy == 0) && !m_rst && !flush;
            m_rst = 0;
            e_re = 0; e_we = 0; e_mis = 0; e_be = 0; e_rv = 0;
            if (p_stage == 1) p_stage = flush ? 0 : 2;
            else if (p_stage == 2) begin
                if (!flush) begin e_rv = 1; e_rdata = p_data; e_rrd = p_rd; end
                p_stage = 0;
            end
            if (m_busy > 0) m_busy = flush ? 0 : m_busy - 1;
            if (req_valid && rdy) begin
                nb  = (req_f3[1:0] == 2'b00) ? 1 : (req_f3[1:0] == 2'b01) ? 2 : 4;
                off = req_addr[1:0];
                wi  = int'(req_addr[ADDR_W-1:2]);
                mis = (nb == 2 && off[0]) || (nb == 4 && off != 2'b00);
                e_addr = req_addr[ADDR_W-1:0] & 10'h3FC;
                for (int l = 0; l < 4; l++) e_wdata[8*l +: 8] = req_wdata[8*(l % nb) +: 8];
                m_busy = 1;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
                if (mis) e_mis = 1;
`else
                if (mis) off = (nb == 2) ? (off & 2'b10) : 2'b00;
                mis = 0;
`endif
                if (!mis && req_we) begin
                    e_we = 1;
                    for (int b = 0; b < nb; b++) begin
                        e_be[int'(off) + b] = 1'b1;
                        mmem[wi][8*(int'(off) + b) +: 8] = req_wdata[8*b +: 8];
                    end
                end else if (!mis) begin
                    e_re = 1;
                    v = 0;
                    for (int b = 0; b < nb; b++) v[8*b +: 8] = mmem[wi][8*(int'(off) + b) +: 8];
                    if (nb < 4 && !req_f3[2] && v[8*nb-1])
                        for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
                    p_data = v; p_rd = req_rd; p_stage = 1; m_busy = 3;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        #1;
        if (model_on) begin
            chk("ready", 32'(req_ready), 32'((m_busy == 0) && !m_rst && !flush));
            chk("mem_re", 32'(mem_re), 32'(e_re));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("misalign", 32'(misalign), 32'(e_mis));
            chk("mem_be", 32'(mem_be), 32'(e_be));
            if (e_re || e_we) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            chk("resp_valid", 32'(resp_valid), 32'(e_rv && !flush));
            chk("resp_data", resp_data, e_rdata);
            chk("resp_rd", 32'(resp_rd), 32'(e_rrd));
        end
    end

    // Directed helpers. send() returns at negedge+1 of the ISSUE cycle.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
        int n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_we = we; req_f3 = f3; req_addr = a; req_wdata = d; req_rd = rd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
        #1;
    endtask

    task automatic wait2();
        @(negedge clk); #1;
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // SW 0x008
        send(1'b1, 3'b010, 32'h008, 32'hDEADBEEF, 5'd0);
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_be", 32'(mem_be), 32'hF);
        chk("sw_addr", 32'(mem_addr), 32'h008);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_ready_low", 32'(req_ready), 32'd0);

        // LB / LBU 0x00B
        poke(2, 32'h80FF1234);
        send(1'b0, 3'b000, 32'h00B, 32'h0, 5'd5);
        chk("lb_re", 32'(mem_re), 32'd1);
        chk("lb_addr", 32'(mem_addr), 32'h008);
        wait2();
        chk("lb_valid", 32'(resp_valid), 32'd1);
        chk("lb_data", resp_data, 32'hFFFFFF80);
        chk("lb_rd", 32'(resp_rd), 32'd5);
        send(1'b0, 3'b100, 32'h00B, 32'h0, 5'd5);
        wait2();
        chk("lbu_data", resp_data, 32'h00000080);

        // SH / LHU 0x006
        send(1'b1, 3'b001, 32'h006, 32'h1234ABCD, 5'd0);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        poke(1, 32'hABCD0000);
        send(1'b0, 3'b101, 32'h006, 32'h0, 5'd7);
        wait2();
        chk("lhu_data", resp_data, 32'h0000ABCD);

        // LH 0x005 (misaligned)
        poke(1, 32'hF00DF00D);
        send(1'b0, 3'b001, 32'h005, 32'h0, 5'd9);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        chk("lh_mis_pulse", 32'(misalign), 32'd1);
        chk("lh_mis_re", 32'(mem_re), 32'd0);
        wait2();
        chk("lh_mis_no_resp", 32'(resp_valid), 32'd0);
`else
        chk("lh_mis_flag", 32'(misalign), 32'd0);
        chk("lh_mis_addr", 32'(mem_addr), 32'h004);
        wait2();
        chk("lh_mis_valid", 32'(resp_valid), 32'd1);
        chk("lh_mis_data", resp_data, 32'hFFFFF00D);
`endif

        // LW flushed in WAIT
        send(1'b0, 3'b010, 32'h010, 32'h0, 5'd3);
        @(negedge clk); flush = 1'b1; #1;
        chk("flush_wait_valid", 32'(resp_valid), 32'd0);
        @(negedge clk); flush = 1'b0; #1;
        chk("flush_after_valid", 32'(resp_valid), 32'd0);
        chk("flush_after_ready", 32'(req_ready), 32'd1);

        // Reset during ISSUE of an SW
        send(1'b1, 3'b010, 32'h020, 32'h11223344, 5'd0);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_issue_we", 32'(mem_we), 32'd0);
        chk("rst_issue_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_rel_ready", 32'(req_ready), 32'd1);
        chk("rst_rel_valid", 32'(resp_valid), 32'd0);
        send(1'b0, 3'b010, 32'h020, 32'h0, 5'd1);
        wait2();
        chk("lw_after_rst", resp_data, 32'h11223344);

        // Randomized traffic, flushes and the odd reset
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] a;
            @(negedge clk);
            a = $urandom();
            a[ADDR_W-1:0] = 10'($urandom_range(0, 127));
            req_valid = ($urandom_range(0, 99) < 60);
            req_we    = $urandom_range(0, 1) == 1;
            req_f3    = 3'($urandom_range(0, 7));
            req_addr  = a;
            req_wdata = $urandom();
            req_rd    = 5'($urandom_range(0, 31));
            flush     = ($urandom_range(0, 99) < 7);
            rst_n     = ($urandom_range(0, 999) >= 5);
        end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
